sccb_slave: RTL and testbench

SCCB_SLAVE -- requirements
Module: sccb_slave

---
 rtl/sccb_pkg.sv | 21 ++
 rtl/sccb_bus_sync.sv | 52 +++++
 rtl/sccb_slave.sv | 200 ++++++++++++++++++++
 tb/tb_sccb_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB types and constants (slave FSM states, default device ID, ACK levels)
package sccb_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEVID,
      ST_ACK_ID,
      ST_SUBADDR,
      ST_ACK_SUB,
      ST_WDATA,
      ST_ACK_DATA,
      ST_RDATA,
      ST_RNA,
      ST_IGNORE
   } sccb_state_t;

   localparam logic [7:0] SCCB_DEV_ID_DEFAULT = 8'h42;
   localparam logic       SCCB_ACK            = 1'b0;
   localparam logic       SCCB_NACK           = 1'b1;

endpackage

// File: rtl/sccb_bus_sync.sv
// rtl/sccb_bus_sync.sv - SCL/SDA synchronizer with SCL edge and START/STOP pulse generation
module sccb_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Synchronizer chains plus one delayed copy for edge detection; idle bus level is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q[0] <= scl_i;
         sda_sync_q[0] <= sda_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_q[i] <= scl_sync_q[i-1];
            sda_sync_q[i] <= sda_sync_q[i-1];
         end
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign sda_o      = sda_s;
   assign scl_rise_o = scl_s & ~scl_prev_q;
   assign scl_fall_o = ~scl_s & scl_prev_q;
   // SDA may only change while SCL is low, so an SDA edge with SCL held high is a bus condition
   assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB register slave; read path enabled by SCCB_SLAVE_READ_EN
module sccb_slave
   import sccb_pkg::*;
#(
   parameter logic [7:0] DEV_ID      = SCCB_DEV_ID_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

`ifdef SCCB_SLAVE_READ_EN
   localparam logic READ_EN = 1'b1;
`else
   localparam logic READ_EN = 1'b0;
   logic rd_data_unused;
   assign rd_data_unused = ^rd_data;
`endif

   logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

   sccb_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bus_sync (
      .clk        (clk),
      .reset      (reset),
      .scl_i      (scl),
      .sda_i      (sda_i),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (bus_start),
      .stop_o     (bus_stop)
   );

   sccb_state_t state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        sda_oe_q, sda_oe_d;
   logic        wr_valid_q, wr_valid_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  rd_addr_q, rd_addr_d;
   logic        busy_q, busy_d;

   // State and datapath registers; async reset releases SDA immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         rd_addr_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_addr_q  <= rd_addr_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state: bus conditions override everything, then per-state bit handling
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_addr_d  = rd_addr_q;
      busy_d     = busy_q;

      if (bus_stop) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (bus_start) begin
         state_d   = ST_DEVID;
         bit_cnt_d = 3'd0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_DEVID, ST_SUBADDR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ST_DEVID) begin
                        // Reads are only acknowledged when the read path exists
                        if ((shift_d[7:1] == DEV_ID[7:1]) && (READ_EN || !sda_s)) begin
                           state_d = ST_ACK_ID;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = ST_IGNORE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == ST_SUBADDR) begin
                        state_d = ST_ACK_SUB;
                     end else begin
                        state_d = ST_ACK_DATA;
                     end
                  end
               end
            end
            ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: begin
               // First SCL fall drives the ACK, second fall releases it and ends the slot
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = ~SCCB_ACK;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 3'd0;
                     if (state_q == ST_ACK_ID) begin
                        if (READ_EN && shift_q[0]) begin
                           state_d  = ST_RDATA;
                           shift_d  = rd_data;
                           sda_oe_d = ~rd_data[7];
                        end else begin
                           state_d = ST_SUBADDR;
                        end
                     end else if (state_q == ST_ACK_SUB) begin
                        rd_addr_d = shift_q;
                        state_d   = ST_WDATA;
                     end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rd_addr_q;
                        wr_data_d  = shift_q;
                        state_d    = ST_IGNORE;
                     end
                  end
               end
            end
`ifdef SCCB_SLAVE_READ_EN
            ST_RDATA: begin
               if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_RNA;
                  end
               end
            end
            ST_RNA: begin
               // Hold the LSB until SCL falls so SDA never moves while SCL is high
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
               end
               if (scl_rise) begin
                  state_d = ST_IGNORE;
               end
            end
`else
            ST_RDATA, ST_RNA: begin
               state_d  = ST_IGNORE;
               sda_oe_d = 1'b0;
            end
`endif
            ST_IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_addr  = rd_addr_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - directed self-checking bench for sccb_slave
module tb_sccb_slave;

   localparam int Q = 80;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       msda = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int         wr_cnt = 0;
   int         oe_rise = 0;
   logic       oe_prev = 1'b0;
   logic [7:0] wr_addr_seen = 8'h00;
   logic [7:0] wr_data_seen = 8'h00;

   assign sda_line = msda & ~sda_oe;

   always #5 clk = ~clk;

   sccb_slave dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda_i    (sda_line),
      .sda_oe   (sda_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   // Count write pulses and SDA-drive assertions away from the active edge
   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt       <= wr_cnt + 1;
         wr_addr_seen <= wr_addr;
         wr_data_seen <= wr_data;
      end
      if (sda_oe && !oe_prev) oe_rise <= oe_rise + 1;
      oe_prev <= sda_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_start();
      msda = 1'b1; #Q;
      scl  = 1'b1; #Q;
      msda = 1'b0; #Q;
      scl  = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      msda = 1'b0; #Q;
      scl  = 1'b1; #Q;
      msda = 1'b1; #Q;
   endtask

   task automatic send_bit(input logic b, output logic s);
      msda = b;    #Q;
      scl  = 1'b1; #Q;
      s = sda_line; #Q;
      scl  = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, ack);
   endtask

   task automatic read_byte(output logic [7:0] val);
      logic s;
      val = 8'h00;
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, s);
         val = {val[6:0], s};
      end
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rv;
      int         wr_base;
      int         oe_base;

      repeat (3) @(negedge clk);
      check("reset_sda_oe", sda_oe, 0);
      check("reset_wr_valid", wr_valid, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Plain register write
      wr_base = wr_cnt; oe_base = oe_rise;
      bus_start();
      write_byte(8'h42, ack); check("wr_ack_id", ack, 0);
      check("wr_busy_after_id", busy, 1);
      write_byte(8'h12, ack); check("wr_ack_sub", ack, 0);
      write_byte(8'h80, ack); check("wr_ack_data", ack, 0);
      check("wr_busy_before_stop", busy, 1);
      bus_stop();
      repeat (10) @(negedge clk);
      check("wr_busy_after_stop", busy, 0);
      check("wr_count", wr_cnt - wr_base, 1);
      check("wr_addr", wr_addr_seen, 8'h12);
      check("wr_data", wr_data_seen, 8'h80);
      check("wr_ack_lows", oe_rise - oe_base, 3);
      check("wr_rd_addr", rd_addr, 8'h12);

      // Foreign device ID is never acknowledged
      wr_base = wr_cnt; oe_base = oe_rise;
      bus_start();
      write_byte(8'h60, ack); check("id_nack_id", ack, 1);
      write_byte(8'h12, ack); check("id_nack_sub", ack, 1);
      write_byte(8'h80, ack); check("id_nack_data", ack, 1);
      bus_stop();
      repeat (10) @(negedge clk);
      check("id_oe_never", oe_rise - oe_base, 0);
      check("id_no_write", wr_cnt - wr_base, 0);
      check("id_busy", busy, 0);

      // Partial data byte aborted by STOP, then a normal write
      wr_base = wr_cnt;
      bus_start();
      write_byte(8'h42, ack); check("part_ack_id", ack, 0);
      write_byte(8'h3A, ack); check("part_ack_sub", ack, 0);
      send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
      bus_stop();
      repeat (10) @(negedge clk);
      check("part_no_write", wr_cnt - wr_base, 0);
      check("part_busy", busy, 0);
      check("part_rd_addr", rd_addr, 8'h3A);
      check("part_sda_oe", sda_oe, 0);
      bus_start();
      write_byte(8'h42, ack); check("part2_ack_id", ack, 0);
      write_byte(8'h3A, ack); check("part2_ack_sub", ack, 0);
      write_byte(8'h04, ack); check("part2_ack_data", ack, 0);
      bus_stop();
      repeat (10) @(negedge clk);
      check("part2_count", wr_cnt - wr_base, 1);
      check("part2_addr", wr_addr_seen, 8'h3A);
      check("part2_data", wr_data_seen, 8'h04);

      // Repeated START after an acknowledged ID
      wr_base = wr_cnt;
      bus_start();
      write_byte(8'h42, ack); check("rs_ack_first", ack, 0);
      bus_start();
      write_byte(8'h42, ack); check("rs_ack_id", ack, 0);
      write_byte(8'h11, ack); check("rs_ack_sub", ack, 0);
      write_byte(8'h80, ack); check("rs_ack_data", ack, 0);
      bus_stop();
      repeat (10) @(negedge clk);
      check("rs_count", wr_cnt - wr_base, 1);
      check("rs_addr", wr_addr_seen, 8'h11);
      check("rs_data", wr_data_seen, 8'h80);

      // Read sequence: set subaddress, then read with ID bit0 set
      wr_base = wr_cnt;
      bus_start();
      write_byte(8'h42, ack); check("rd_ack_id_w", ack, 0);
      write_byte(8'h0A, ack); check("rd_ack_sub", ack, 0);
      bus_stop();
      repeat (10) @(negedge clk);
      check("rd_addr_latched", rd_addr, 8'h0A);
      rd_data = 8'h76;
      bus_start();
      write_byte(8'h43, ack);
`ifdef SCCB_SLAVE_READ_EN
      check("rd_ack_id_r", ack, 0);
      read_byte(rv);
      check("rd_bits", rv, 8'h76);
      send_bit(1'b1, s);
      check("rd_rna_line", s, 1);
      check("rd_rna_oe", sda_oe, 0);
`else
      check("rd_noread_nack", ack, 1);
      read_byte(rv);
      check("rd_noread_line", rv, 8'hFF);
`endif
      bus_stop();
      repeat (10) @(negedge clk);
      check("rd_no_write", wr_cnt - wr_base, 0);
      check("rd_busy", busy, 0);

      // Reset while the slave drives an ACK low
      wr_base = wr_cnt;
      bus_start();
      write_byte(8'h42, ack); check("rst_ack_id", ack, 0);
      write_byte(8'h12, ack); check("rst_ack_sub", ack, 0);
      for (int i = 7; i >= 0; i--) send_bit(1'b1, s);
      check("rst_oe_driving", sda_oe, 1);
      reset = 1'b1;
      #1;
      check("rst_oe_async", sda_oe, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      send_bit(1'b1, s);
      check("rst_line_released", s, 1);
      send_bit(1'b0, s); send_bit(1'b1, s);
      bus_stop();
      repeat (10) @(negedge clk);
      check("rst_no_write", wr_cnt - wr_base, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_valid", wr_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
